sys_ctrl_rf: RTL and testbench

- Command front end for the register file; sits directly upstream of it.
- Consumes parallel bytes from the UART receiver, decodes write and read commands, and issues single-cycle WrEn/RdEn strobes to the register file.
- Captures read data and hands it to the UART transmitter.
- Register-file path only; ALU commands are out of scope.

---
 rtl/sys_ctrl_rf.sv | 164 ++++++++++++++++
 tb/tb_sys_ctrl_rf.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_rf.sv
// Command front end for the register file: decodes write/read commands from
// the UART receive byte stream, strobes the register file, and forwards read
// data to the UART transmitter.
module sys_ctrl_rf #(
    parameter int unsigned          DATA_SIZE     = 8,
    parameter int unsigned          ADDRESS_WIDTH = 4,
    parameter logic [DATA_SIZE-1:0] WR_CMD        = 8'hAA,
    parameter logic [DATA_SIZE-1:0] RD_CMD        = 8'hBB,
    parameter int unsigned          RD_TIMEOUT    = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_SIZE-1:0]     RX_P_DATA,
    input  logic                     RX_D_VLD,
    output logic [ADDRESS_WIDTH-1:0] Address,
    output logic                     WrEn,
    output logic                     RdEn,
    output logic [DATA_SIZE-1:0]     WrData,
    input  logic [DATA_SIZE-1:0]     RdData,
    input  logic                     RdData_Valid,
    output logic [DATA_SIZE-1:0]     TX_P_DATA,
    output logic                     TX_D_VLD,
    input  logic                     TX_BUSY,
    output logic                     CMD_ERR
);

    localparam int unsigned CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        TX_SEND = 3'd5
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_d;
    logic                     wren_d;
    logic                     rden_d;
    logic [DATA_SIZE-1:0]     wrdata_d;
    logic [DATA_SIZE-1:0]     txd_d;
    logic                     txv_d;
    logic                     err_d;
    logic [DATA_SIZE-1:0]     hold_q, hold_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     addr_bad;

    // Address byte is illegal when any bit above the register-file address is set
    assign addr_bad = (RX_P_DATA[DATA_SIZE-1:ADDRESS_WIDTH] != '0);

    // State, holding register, timeout counter and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            cnt_q     <= '0;
            Address   <= '0;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            WrData    <= '0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
            CMD_ERR   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            Address   <= addr_d;
            WrEn      <= wren_d;
            RdEn      <= rden_d;
            WrData    <= wrdata_d;
            TX_P_DATA <= txd_d;
            TX_D_VLD  <= txv_d;
            CMD_ERR   <= err_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        addr_d   = Address;
        wren_d   = 1'b0;
        rden_d   = 1'b0;
        wrdata_d = WrData;
        txd_d    = TX_P_DATA;
        txv_d    = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == WR_CMD) begin
                        state_d = WR_ADDR;
                    end else if (RX_P_DATA == RD_CMD) begin
                        state_d = RD_ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    if (addr_bad) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        addr_d  = RX_P_DATA[ADDRESS_WIDTH-1:0];
                        state_d = WR_DATA;
                    end
                end
            end
            WR_DATA: begin
                // Any byte here is payload, including command codes
                if (RX_D_VLD) begin
                    wrdata_d = RX_P_DATA;
                    wren_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    if (addr_bad) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        addr_d  = RX_P_DATA[ADDRESS_WIDTH-1:0];
                        rden_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                err_d = RX_D_VLD;
                cnt_d = cnt_q + CNT_W'(1);
                if (RdData_Valid) begin
                    hold_d  = RdData;
                    cnt_d   = '0;
                    state_d = TX_SEND;
                end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            TX_SEND: begin
                err_d = RX_D_VLD;
                if (!TX_BUSY) begin
                    txd_d   = hold_q;
                    txv_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sys_ctrl_rf.sv
// Bench for sys_ctrl_rf: table-driven command vectors plus hand-written
// sequences, with a cycle-stamped scoreboard for strobes, TX bytes and errors.
module tb_sys_ctrl_rf;

    logic       CLK;
    logic       RST;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic [3:0] Address;
    logic       WrEn;
    logic       RdEn;
    logic [7:0] WrData;
    logic [7:0] RdData;
    logic       RdData_Valid;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       TX_BUSY;
    logic       CMD_ERR;

    sys_ctrl_rf dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_P_DATA    (RX_P_DATA),
        .RX_D_VLD     (RX_D_VLD),
        .Address      (Address),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .WrData       (WrData),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .TX_P_DATA    (TX_P_DATA),
        .TX_D_VLD     (TX_D_VLD),
        .TX_BUSY      (TX_BUSY),
        .CMD_ERR      (CMD_ERR)
    );

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        int         due;
    } ev_t;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         n;
        bit         wr;
        bit         rd;
        bit         err;
        logic [3:0] addr;
        logic [7:0] data;
    } vec_t;

    ev_t  q_wr[$];
    ev_t  q_rd[$];
    ev_t  q_tx[$];
    ev_t  q_err[$];
    int   tests;
    int   failed;
    int   cyc;
    int   rf_lat;
    int   rd_cnt;
    logic [3:0] rd_a;
    logic [7:0] mem [16];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Register-file model: responds rf_lat cycles after RdEn (0 = never)
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RdData_Valid <= 1'b0;
            RdData       <= 8'h00;
            rd_cnt       <= 0;
            rd_a         <= 4'h0;
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        end else begin
            RdData_Valid <= 1'b0;
            if (WrEn) mem[Address] <= WrData;
            if (RdEn) begin
                rd_a <= Address;
                if (rf_lat == 1) begin
                    RdData_Valid <= 1'b1;
                    RdData       <= mem[Address];
                end else if (rf_lat > 1) begin
                    rd_cnt <= rf_lat - 1;
                end
            end else if (rd_cnt > 0) begin
                rd_cnt <= rd_cnt - 1;
                if (rd_cnt == 1) begin
                    RdData_Valid <= 1'b1;
                    RdData       <= mem[rd_a];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic chk_ev(input string nm, input logic [3:0] ga, input logic [7:0] gd, input ev_t e);
        tests++;
        if (ga !== e.addr || gd !== e.data || cyc != e.due) begin
            failed++;
            $display("FAIL %s: got addr=%0h data=%0h cyc=%0d expected addr=%0h data=%0h cyc=%0d",
                     nm, ga, gd, cyc, e.addr, e.data, e.due);
        end
    endtask

    task automatic unexpected(input string nm);
        tests++;
        failed++;
        $display("FAIL %s: unexpected pulse at cyc %0d (addr=%0h wd=%0h tx=%0h)",
                 nm, cyc, Address, WrData, TX_P_DATA);
    endtask

    // Output monitor / scoreboard, sampled on the falling edge
    always @(negedge CLK) begin
        ev_t e;
        if (RST) begin
            if (WrEn && RdEn) unexpected("wr_rd_overlap");
            if (TX_D_VLD && TX_BUSY) unexpected("tx_while_busy");
            if (WrEn) begin
                if (q_wr.size() == 0) unexpected("wren");
                else begin e = q_wr.pop_front(); chk_ev("wren", Address, WrData, e); end
            end
            if (RdEn) begin
                if (q_rd.size() == 0) unexpected("rden");
                else begin e = q_rd.pop_front(); chk_ev("rden", Address, 8'h00, e); end
            end
            if (TX_D_VLD) begin
                if (q_tx.size() == 0) unexpected("tx");
                else begin e = q_tx.pop_front(); chk_ev("tx", 4'h0, TX_P_DATA, e); end
            end
            if (CMD_ERR) begin
                if (q_err.size() == 0) unexpected("cmd_err");
                else begin e = q_err.pop_front(); chk_ev("cmd_err", 4'h0, 8'h00, e); end
            end
        end
    end

    // Drive one byte for one cycle; returns the cycle stamp it was driven in
    task automatic send(input logic [7:0] b, output int t);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        t         = cyc;
        @(posedge CLK);
        #1;
        RX_D_VLD  = 1'b0;
    endtask

    task automatic push(ref ev_t q[$], input logic [3:0] a, input logic [7:0] d, input int due);
        ev_t e;
        e.addr = a;
        e.data = d;
        e.due  = due;
        q.push_back(e);
    endtask

    task automatic drain(input string nm);
        repeat (14) @(negedge CLK);
        chk({nm, "_wr_left"},  32'(q_wr.size()),  32'd0);
        chk({nm, "_rd_left"},  32'(q_rd.size()),  32'd0);
        chk({nm, "_tx_left"},  32'(q_tx.size()),  32'd0);
        chk({nm, "_err_left"}, 32'(q_err.size()), 32'd0);
        q_wr.delete(); q_rd.delete(); q_tx.delete(); q_err.delete();
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_addr"},   32'(Address),   32'd0);
        chk({nm, "_wren"},   32'(WrEn),      32'd0);
        chk({nm, "_rden"},   32'(RdEn),      32'd0);
        chk({nm, "_wrdata"}, 32'(WrData),    32'd0);
        chk({nm, "_txdata"}, 32'(TX_P_DATA), 32'd0);
        chk({nm, "_txvld"},  32'(TX_D_VLD),  32'd0);
        chk({nm, "_err"},    32'(CMD_ERR),   32'd0);
    endtask

    function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input int n, input bit wr, input bit rd, input bit err,
                                input logic [3:0] a, input logic [7:0] d);
        vec_t v;
        v.b0 = b0; v.b1 = b1; v.b2 = b2; v.n = n;
        v.wr = wr; v.rd = rd; v.err = err; v.addr = a; v.data = d;
        return v;
    endfunction

    vec_t tbl [12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int r;
        logic [7:0] b;
        tests     = 0;
        failed    = 0;
        cyc       = 0;
        rf_lat    = 1;
        RST       = 1'b0;
        RX_P_DATA = 8'h00;
        RX_D_VLD  = 1'b0;
        TX_BUSY   = 1'b0;

        //          b0     b1     b2     n  wr rd err addr   data
        tbl[0]  = mk(8'hAA, 8'h05, 8'h3C, 3, 1, 0, 0, 4'h5, 8'h3C);
        tbl[1]  = mk(8'hBB, 8'h05, 8'h00, 2, 0, 1, 0, 4'h5, 8'h3C);
        tbl[2]  = mk(8'h12, 8'h00, 8'h00, 1, 0, 0, 1, 4'h0, 8'h00);
        tbl[3]  = mk(8'hAA, 8'h15, 8'h00, 2, 0, 0, 1, 4'h0, 8'h00);
        tbl[4]  = mk(8'hBB, 8'h25, 8'h00, 2, 0, 0, 1, 4'h0, 8'h00);
        tbl[5]  = mk(8'hAA, 8'h0A, 8'hAA, 3, 1, 0, 0, 4'hA, 8'hAA);
        tbl[6]  = mk(8'hBB, 8'h0A, 8'h00, 2, 0, 1, 0, 4'hA, 8'hAA);
        tbl[7]  = mk(8'hAA, 8'h0F, 8'h01, 3, 1, 0, 0, 4'hF, 8'h01);
        tbl[8]  = mk(8'hBB, 8'h0F, 8'h00, 2, 0, 1, 0, 4'hF, 8'h01);
        tbl[9]  = mk(8'hBB, 8'hAA, 8'h00, 2, 0, 0, 1, 4'h0, 8'h00);
        tbl[10] = mk(8'hAA, 8'h00, 8'hFF, 3, 1, 0, 0, 4'h0, 8'hFF);
        tbl[11] = mk(8'hBB, 8'h00, 8'h00, 2, 0, 1, 0, 4'h0, 8'hFF);

        repeat (3) @(negedge CLK);
        chk_outputs_zero("reset");
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // Table-driven commands, nominal one-cycle register-file latency
        for (int v = 0; v < 12; v++) begin
            t = 0;
            for (int i = 0; i < tbl[v].n; i++) begin
                b = (i == 0) ? tbl[v].b0 : (i == 1) ? tbl[v].b1 : tbl[v].b2;
                send(b, t);
            end
            if (tbl[v].wr)  push(q_wr, tbl[v].addr, tbl[v].data, t + 1);
            if (tbl[v].rd) begin
                push(q_rd, tbl[v].addr, 8'h00, t + 1);
                push(q_tx, 4'h0, tbl[v].data, t + 4);
            end
            if (tbl[v].err) push(q_err, 4'h0, 8'h00, t + 1);
            drain($sformatf("vec%0d", v));
        end

        // Read with transmitter busy for 20+ cycles after capture
        TX_BUSY = 1'b1;
        send(8'hBB, t);
        send(8'h05, t);
        push(q_rd, 4'h5, 8'h00, t + 1);
        repeat (23) @(negedge CLK);
        r = cyc;
        TX_BUSY = 1'b0;
        push(q_tx, 4'h0, 8'h3C, r + 1);
        drain("tx_busy");

        // Read timeout: register file never answers
        rf_lat = 0;
        send(8'hBB, t);
        send(8'h02, t);
        push(q_rd, 4'h2, 8'h00, t + 1);
        push(q_err, 4'h0, 8'h00, t + 9);
        drain("rd_timeout");

        // Overrun byte while waiting for read data; read still completes
        rf_lat = 4;
        send(8'hBB, t);
        send(8'h05, t);
        push(q_rd, 4'h5, 8'h00, t + 1);
        push(q_tx, 4'h0, 8'h3C, t + 7);
        send(8'h77, r);
        push(q_err, 4'h0, 8'h00, r + 1);
        drain("overrun");
        rf_lat = 1;

        // Reset mid write command discards it
        send(8'hAA, t);
        send(8'h05, t);
        @(negedge CLK);
        chk("pre_reset_addr", 32'(Address), 32'h5);
        RST = 1'b0;
        #1;
        chk_outputs_zero("mid_reset");
        @(negedge CLK);
        RST = 1'b1;
        send(8'h3C, t);
        push(q_err, 4'h0, 8'h00, t + 1);
        drain("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
